// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Optional trace output is enabled with the RF_TRACE_EN macro (see regfile_mp_sb.sv).
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // Architectural zero register: reads as zero, never pending.
  localparam int ZERO_REG = 0;

  // Bit offset of port k inside a packed per-port bus of w-bit fields.
  function automatic int port_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue sets a destination pending, writeback clears it.
// A set and a clear of the same register in one cycle leave it pending,
// because the set belongs to a newer producer. Register 0 is never pending.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [ADDR_W-1:0]    alloc_addr,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] busy_q;

  // Next busy vector: clear first, then set, so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && (clr_addr != ZERO_ADDR)) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (alloc_en && (alloc_addr != ZERO_ADDR)) begin
      busy_d[alloc_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Busy register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write-through bypass and busy scoreboard.
// Define RF_TRACE_EN to print one trace line per committed register write.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [31:0]              wr_pc,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] rf_d [DEPTH];
  logic [DATA_W-1:0] rf_q [DEPTH];
  logic              wr_commit;

  assign wr_commit = wr_en && (wr_addr != ZERO_ADDR);

  // Next register contents: apply the writeback, keep r0 pinned at zero.
  always_comb begin
    rf_d = rf_q;
    if (wr_commit) begin
      rf_d[wr_addr] = wr_data;
    end
    rf_d[ZERO_REG] = '0;
  end

  // Storage update with synchronous active-low clear of every register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .clr_en    (wr_en),
    .clr_addr  (wr_addr),
    .busy_vec  (busy_vec)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];
    assign hit  = wr_commit && (wr_addr == addr);

    // Read mux: zero register, then same-cycle writeback, then storage.
    always_comb begin
      data = '0;
      if (addr == ZERO_ADDR) begin
        data = '0;
      end else if (hit) begin
        data = wr_data;
      end else begin
        data = rf_q[addr];
      end
    end

    assign rd_data[port_lsb(k, DATA_W) +: DATA_W] = data;
    assign rd_busy[k] = (addr != ZERO_ADDR) && busy_vec[addr] && !hit;
  end

`ifdef RF_TRACE_EN
  // Trace each committed write at the edge that updates the register.
  always_ff @(posedge clk) begin
    if (reset && wr_commit) begin
      $display("%0t@%h: $%0d <= %h", $time, wr_pc, wr_addr, wr_data);
    end
  end
`else
  logic unused_wr_pc;
  assign unused_wr_pc = ^wr_pc;
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed testbench for regfile_mp_sb built with four read ports.
module tb_regfile_mp_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 4;

  logic                     clk;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [31:0]              wr_pc;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic [2**ADDR_W-1:0]     busy_vec;

  int checkCount;
  int failCount;

  regfile_mp_sb #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_pc     (wr_pc),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .busy_vec  (busy_vec)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setRead(input int k, input logic [ADDR_W-1:0] a);
    rd_addr[k*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [31:0] portData(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  // Drive writeback and alloc controls for the coming edge, then let logic settle.
  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa, input logic [31:0] wd,
                               input logic ae, input logic [ADDR_W-1:0] aa);
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    wr_pc      = 32'h1000 + {27'd0, wa};
    alloc_en   = ae;
    alloc_addr = aa;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset      = 1'b0;
    rd_addr    = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    #1;

    $display("[TB] reset state");
    setRead(0, 5'd5); setRead(1, 5'd6); setRead(2, 5'd31); setRead(3, 5'd0);
    #1;
    checkOutput("rst_data0", portData(0), 32'h0);
    checkOutput("rst_data2", portData(2), 32'h0);
    checkOutput("rst_busy", {28'd0, rd_busy}, 32'h0);
    checkOutput("rst_busyvec", busy_vec, 32'h0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("pre_rst_r5", portData(0), 32'hDEADBEEF);
    checkOutput("pre_rst_busyvec", busy_vec, 32'h0000_0040);
    checkOutput("pre_rst_busy1", {31'd0, rd_busy[1]}, 32'h1);
    reset = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'h00000001, 1'b1, 5'd8);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("post_rst_r5", portData(0), 32'h0);
    checkOutput("post_rst_busyvec", busy_vec, 32'h0);
    checkOutput("post_rst_busy", {28'd0, rd_busy}, 32'h0);

    $display("[TB] bypass");
    setRead(1, 5'd7);
    applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
    checkOutput("byp_same_cycle", portData(1), 32'h12345678);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("byp_next_cycle", portData(1), 32'h12345678);

    $display("[TB] zero register");
    setRead(0, 5'd0);
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    checkOutput("r0_same_cycle", portData(0), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("r0_after", portData(0), 32'h0);
    checkOutput("r0_busyvec", busy_vec, 32'h0);

    $display("[TB] scoreboard");
    setRead(2, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    checkOutput("sb_c1_busy", {31'd0, rd_busy[2]}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("sb_c2_busy", {31'd0, rd_busy[2]}, 32'h1);
    checkOutput("sb_c2_busyvec", busy_vec, 32'h0000_0200);
    nextCycle();
    applyStimulus(1'b1, 5'd9, 32'h00000055, 1'b0, 5'd0);
    checkOutput("sb_c3_busy", {31'd0, rd_busy[2]}, 32'h0);
    checkOutput("sb_c3_data", portData(2), 32'h00000055);
    checkOutput("sb_c3_busyvec", busy_vec, 32'h0000_0200);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("sb_c4_busyvec", busy_vec, 32'h0);
    checkOutput("sb_c4_data", portData(2), 32'h00000055);

    $display("[TB] set/clear collision");
    setRead(3, 5'd4);
    applyStimulus(1'b1, 5'd4, 32'h0000000A, 1'b1, 5'd4);
    checkOutput("col_pre_busy", {31'd0, rd_busy[3]}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("col_busyvec", busy_vec, 32'h0000_0010);
    checkOutput("col_data", portData(3), 32'h0000000A);
    checkOutput("col_busy", {31'd0, rd_busy[3]}, 32'h1);
    applyStimulus(1'b1, 5'd4, 32'h0000000B, 1'b1, 5'd10);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("clr4_set10", busy_vec, 32'h0000_0400);
    checkOutput("clr4_data", portData(3), 32'h0000000B);

    $display("[TB] four ports");
    applyStimulus(1'b1, 5'd3, 32'h00000011, 1'b0, 5'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd31, 32'h00000022, 1'b0, 5'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    setRead(0, 5'd3); setRead(1, 5'd0); setRead(2, 5'd31); setRead(3, 5'd3);
    #1;
    checkOutput("p4_port0", portData(0), 32'h00000011);
    checkOutput("p4_port1", portData(1), 32'h0);
    checkOutput("p4_port2", portData(2), 32'h00000022);
    checkOutput("p4_port3", portData(3), 32'h00000011);
    applyStimulus(1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0);
    checkOutput("p4_byp0", portData(0), 32'h00000033);
    checkOutput("p4_byp2", portData(2), 32'h00000022);
    checkOutput("p4_byp3", portData(3), 32'h00000033);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("p4_stored", portData(3), 32'h00000033);
    checkOutput("p4_r10_busy", busy_vec, 32'h0000_0400);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
